// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and the shared coordinate type
package vga_pkg;
  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned H_FRONT      = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BACK       = 48;
  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned V_FRONT      = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BACK       = 33;
  localparam logic        SYNC_ACTIVE  = 1'b0;
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned COORD_RANGE  = 1024;
  typedef logic [9:0] vga_coord_t;
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: wrapping raster counter with look-ahead visible/sync decode
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL,
  parameter int unsigned VISIBLE    = H_VISIBLE,
  parameter int unsigned SYNC_START = H_SYNC_START,
  parameter int unsigned SYNC_END   = H_SYNC_END
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output vga_coord_t count,
  output logic       wrap,
  output vga_coord_t next_count,
  output logic       in_visible_next,
  output logic       in_sync_next
);
  localparam vga_coord_t LAST = vga_coord_t'(TOTAL - 1);
  vga_coord_t count_q, count_d;
  logic [31:0] nx;
  // next count: hold, step, or wrap to zero after the last position
  always_comb begin
    wrap    = adv && (count_q == LAST);
    count_d = adv ? (wrap ? '0 : count_q + vga_coord_t'(1)) : count_q;
  end
  // reset parks on the last position so the first advance lands on zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= LAST;
    else        count_q <= count_d;
  assign nx              = 32'(count_d);
  assign count           = count_q;
  assign next_count      = count_d;
  assign in_visible_next = nx < VISIBLE;
  assign in_sync_next    = (nx >= SYNC_START) && (nx < SYNC_END);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counters with zero-skew registered flags
module vga_timing_gen
  import vga_pkg::vga_coord_t;
#(
  parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_pkg::V_BACK,
  parameter logic        SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_tick
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SS    = H_VISIBLE + H_FRONT;
  localparam int unsigned V_SS    = V_VISIBLE + V_FRONT;
  if (H_TOTAL > vga_pkg::COORD_RANGE || V_TOTAL > vga_pkg::COORD_RANGE) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
  end
  vga_coord_t h_count, h_next, v_count, v_next;
  logic h_wrap, h_vis, h_sync, v_vis, v_sync, frame_wrap_unused;
  logic blank_q, blank_d, hs_q, hs_d, vs_q, vs_d, frame_tick_q, frame_tick_d;
  vga_sync_counter #(
    .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE), .SYNC_START(H_SS), .SYNC_END(H_SS + H_SYNC)
  ) u_h (
    .clk(vga_clk), .rst_n(reset_n), .adv(1'b1), .count(h_count), .wrap(h_wrap),
    .next_count(h_next), .in_visible_next(h_vis), .in_sync_next(h_sync)
  );
  vga_sync_counter #(
    .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE), .SYNC_START(V_SS), .SYNC_END(V_SS + V_SYNC)
  ) u_v (
    .clk(vga_clk), .rst_n(reset_n), .adv(h_wrap), .count(v_count), .wrap(frame_wrap_unused),
    .next_count(v_next), .in_visible_next(v_vis), .in_sync_next(v_sync)
  );
  // flags decoded from next counter values so they line up with DrawX/DrawY
  always_comb begin
    blank_d      = h_vis && v_vis;
    hs_d         = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d         = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_tick_d = (h_next == '0) && (v_next == vga_coord_t'(V_VISIBLE));
  end
  // reset values match the flags of the last pixel of a frame
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      blank_q      <= 1'b0;
      hs_q         <= ~SYNC_ACTIVE;
      vs_q         <= ~SYNC_ACTIVE;
      frame_tick_q <= 1'b0;
    end else begin
      blank_q      <= blank_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      frame_tick_q <= frame_tick_d;
    end
  assign DrawX      = h_count;
  assign DrawY      = v_count;
  assign blank      = blank_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing: pixel coordinates, display-enable, and HS/VS sync.
- Sits directly upstream of every screen renderer (win screens, playfield, scores); they consume DrawX/DrawY/blank on the same vga_clk.
- Also drives hs/vs to the VGA connector and a once-per-frame tick for game-state update logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hs/vs during the sync pulse

Ports:
- vga_clk  in  1  pixel clock, 25 MHz nominal
- reset_n  in  1  asynchronous active-low reset
- DrawX    out 10 horizontal counter, 0..H_TOTAL-1
- DrawY    out 10 vertical counter, 0..V_TOTAL-1
- blank    out 1  1 = visible pixel (display enable); renderers output colour only when 1
- hs       out 1  horizontal sync
- vs       out 1  vertical sync
- frame_tick out 1 one-cycle pulse at start of vertical blanking

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must fit in 10 bits; elaboration fails if not.
- Counters:
  - hc increments every vga_clk and wraps H_TOTAL-1 -> 0.
  - vc increments only when hc wraps; it wraps V_TOTAL-1 -> 0 when hc and vc both wrap.
  - DrawX = hc and DrawY = vc, driven directly from the registers.
- Flags are registered, decoded from the next-state counter values, so every output describes the same pixel in the same cycle (zero relative skew).
- blank = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
- hs = SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE.
- vs = SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), full lines, else ~SYNC_ACTIVE. vs edges coincide with hc = 0.
- frame_tick = 1 for exactly the cycle where (hc,vc) = (0,V_VISIBLE), i.e. (0,480); otherwise 0.
- Reset (async assert, sync-safe deassert not required here):
  - hc = H_TOTAL-1 (799), vc = V_TOTAL-1 (524).
  - blank = 0, hs = vs = ~SYNC_ACTIVE, frame_tick = 0.
  - This is exactly the state of the last pixel of a frame, so flags are consistent during reset.
- First rising edge after reset_n deassert gives (0,0), blank = 1, hs/vs inactive.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). No partial-line or partial-frame state survives.
- Frame period: H_TOTAL*V_TOTAL = 420000 cycles. Visible cycles per frame: 307200.
- No enable and no input handshake: free-running from reset release.

Decomposition:
- Package vga_pkg:
  - default timing constants (H_*/V_* values)
  - derived H_TOTAL/V_TOTAL and sync start/end localparams
  - typedef vga_coord_t = logic [9:0]
- Sub-module vga_sync_counter, instantiated twice (H and V):
  - parameters TOTAL, VISIBLE, SYNC_START, SYNC_END
  - inputs: clock, reset, advance enable
  - outputs: count, wrap, next_count, in_visible_next, in_sync_next
- Top level chains H wrap into the V advance enable and registers the combined flags.

Test Plan:
- Hold reset_n = 0 -> DrawX = 799, DrawY = 524, blank = 0, hs = vs = 1, frame_tick = 0. Release -> next edge gives DrawX = 0, DrawY = 0, blank = 1.
- Run one line -> hs low exactly for DrawX 656..751 (96 cycles). blank high for DrawX 0..639 on DrawY < 480. DrawX wraps 799 -> 0 as DrawY increments by 1.
- Run one full frame -> vs low exactly for DrawY 490..491 (1600 cycles), starting at DrawX = 0. DrawY wraps 524 -> 0.
- Count over 3 frames -> 420000 cycles between frame_tick pulses. Each pulse is 1 cycle wide at (0,480). 307200 blank-high cycles per frame.
- Assert reset_n = 0 asynchronously at (300,200), between clock edges -> outputs reach reset values before the next edge. Release -> sequence restarts at (0,0).
- Scoreboard check every cycle against a reference model (counter-derived flags) -> no mismatch on hs, vs, blank, DrawX or DrawY across 2 frames.
